// File: rtl/dc_ramp_pkg.sv
// Shared definitions for the DC-motor duty profile generator: channel modes
// and a small unsigned clamp helper used when deriving the effective target.
package dc_ramp_pkg;

  // Per-channel operating mode. 2'b11 is not named and behaves as hold.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_TRI  = 2'b01,
    MODE_SLEW = 2'b10
  } mode_t;

  // Clamp an unsigned value into [lo, hi]. Callers guarantee lo <= hi.
  function automatic logic [31:0] clamp_u32(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    logic [31:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/dc_ramp_ch.sv
// One duty channel: duty, sweep direction and done-pulse registers plus the
// per-tick hold / triangle / slew next-state logic. All arithmetic is done one
// bit wider than the duty so that duty+step can never wrap.
module dc_ramp_ch
  import dc_ramp_pkg::*;
#(
  parameter int DUTY_W    = 8,
  parameter int DUTY_MIN  = 1,
  parameter int DUTY_MAX  = 99,
  parameter int DUTY_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] duty,
  output logic              done
);

  localparam int W1 = DUTY_W + 1;
  localparam logic [W1-1:0] MIN_W  = W1'(DUTY_MIN);
  localparam logic [W1-1:0] MAX_W  = W1'(DUTY_MAX);
  localparam logic [W1-1:0] STEP_W = W1'(DUTY_STEP);

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_up_q, dir_up_d;
  logic              done_q, done_d;
  logic [W1-1:0]     duty_w, tgt_w, nxt_w;

  // Next duty/direction/done; only a tick cycle can change anything.
  always_comb begin
    duty_w   = {1'b0, duty_q};
    tgt_w    = W1'(clamp_u32(32'(target), 32'(DUTY_MIN), 32'(DUTY_MAX)));
    nxt_w    = duty_w;
    dir_up_d = dir_up_q;
    done_d   = 1'b0;
    if (tick) begin
      case (mode_t'(mode))
        MODE_TRI: begin
          // An out-of-range duty is pulled back to the violated bound first.
          if (duty_w < MIN_W) begin
            nxt_w = MIN_W;
          end else if (duty_w > MAX_W) begin
            nxt_w = MAX_W;
          end else if (dir_up_q) begin
            if (duty_w + STEP_W >= MAX_W) begin
              nxt_w    = MAX_W;
              dir_up_d = 1'b0;
            end else begin
              nxt_w = duty_w + STEP_W;
            end
          end else begin
            if (duty_w <= MIN_W + STEP_W) begin
              nxt_w    = MIN_W;
              dir_up_d = 1'b1;
            end else begin
              nxt_w = duty_w - STEP_W;
            end
          end
        end
        MODE_SLEW: begin
          if (duty_w < MIN_W) begin
            nxt_w = MIN_W;
          end else if (duty_w > MAX_W) begin
            nxt_w = MAX_W;
          end else if (duty_w < tgt_w) begin
            nxt_w = (duty_w + STEP_W >= tgt_w) ? tgt_w : duty_w + STEP_W;
          end else if (duty_w > tgt_w) begin
            nxt_w = (duty_w <= tgt_w + STEP_W) ? tgt_w : duty_w - STEP_W;
          end
          // Pulse only on the arrival tick, never while parked on the target.
          done_d = (nxt_w == tgt_w) && (duty_w != tgt_w);
        end
        default: begin
        end
      endcase
    end
    duty_d = DUTY_W'(nxt_w);
  end

  // Channel state registers; reset parks the channel at the lower bound, sweeping up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q   <= DUTY_W'(DUTY_MIN);
      dir_up_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      duty_q   <= duty_d;
      dir_up_q <= dir_up_d;
      done_q   <= done_d;
    end
  end

  assign duty = duty_q;
  assign done = done_q;

endmodule

// File: rtl/dc_duty_ramp.sv
// Multi-channel duty-cycle profile generator. A shared step timer produces one
// tick every STEP_US microseconds; each channel advances its duty on that tick
// according to its mode and drives one PWM generator downstream.
module dc_duty_ramp
  import dc_ramp_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int CH_NUM    = 2,
  parameter int DUTY_W    = 8,
  parameter int DUTY_MIN  = 1,
  parameter int DUTY_MAX  = 99,
  parameter int DUTY_STEP = 1,
  parameter int STEP_US   = 20000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [2*CH_NUM-1:0]      ch_mode,
  input  logic [DUTY_W*CH_NUM-1:0] ch_target,
  output logic [DUTY_W*CH_NUM-1:0] dc_duty,
  output logic [CH_NUM-1:0]        ch_done,
  output logic                     tick
);

  localparam int TICK_CYC = STEP_US * CLK_FRE;
  localparam int CNT_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Step timer: free-runs while enabled, held at zero otherwise; tick marks the
  // terminal count and is forced low while reset is asserted.
  always_comb begin
    cnt_d = '0;
    if (enable && (cnt_q != CNT_TERM)) cnt_d = cnt_q + CNT_W'(1);
    tick = enable && (cnt_q == CNT_TERM) && !rst;
  end

  // Step timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    dc_ramp_ch #(
      .DUTY_W   (DUTY_W),
      .DUTY_MIN (DUTY_MIN),
      .DUTY_MAX (DUTY_MAX),
      .DUTY_STEP(DUTY_STEP)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .mode  (ch_mode[2*k +: 2]),
      .target(ch_target[DUTY_W*k +: DUTY_W]),
      .duty  (dc_duty[DUTY_W*k +: DUTY_W]),
      .done  (ch_done[k])
    );
  end

endmodule

// File: tb/tb_dc_duty_ramp.sv
// Directed bench for dc_duty_ramp: three instances sharing stimulus, differing
// only in step size (1, 4, 3), with a 2-cycle tick period.
module tb_dc_duty_ramp;
  import dc_ramp_pkg::*;

  localparam int DW = 8;
  localparam int CH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [2*CH-1:0]  ch_mode;
  logic [DW*CH-1:0] ch_target;

  logic [DW*CH-1:0] duty_s1, duty_s4, duty_s3;
  logic [CH-1:0]    done_s1, done_s4, done_s3;
  logic             tick_s1, tick_s4, tick_s3;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  dc_duty_ramp #(.CLK_FRE(1), .CH_NUM(CH), .DUTY_W(DW), .DUTY_MIN(1), .DUTY_MAX(99),
                 .DUTY_STEP(1), .STEP_US(2)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .ch_mode(ch_mode), .ch_target(ch_target),
    .dc_duty(duty_s1), .ch_done(done_s1), .tick(tick_s1));

  dc_duty_ramp #(.CLK_FRE(1), .CH_NUM(CH), .DUTY_W(DW), .DUTY_MIN(1), .DUTY_MAX(99),
                 .DUTY_STEP(4), .STEP_US(2)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .ch_mode(ch_mode), .ch_target(ch_target),
    .dc_duty(duty_s4), .ch_done(done_s4), .tick(tick_s4));

  dc_duty_ramp #(.CLK_FRE(1), .CH_NUM(CH), .DUTY_W(DW), .DUTY_MIN(1), .DUTY_MAX(99),
                 .DUTY_STEP(3), .STEP_US(2)) u_dut3 (
    .clk(clk), .rst(rst), .enable(enable), .ch_mode(ch_mode), .ch_target(ch_target),
    .dc_duty(duty_s3), .ch_done(done_s3), .tick(tick_s3));

  // Driver tasks -------------------------------------------------------------
  task automatic step_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    ch_mode[2*ch +: 2] = m;
  endtask

  task automatic set_target(input int ch, input logic [DW-1:0] t);
    ch_target[DW*ch +: DW] = t;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    enable    = 1'b0;
    ch_mode   = '0;
    ch_target = '0;
    step_cycle;
    step_cycle;
    @(negedge clk);
    rst = 1'b0;
    step_cycle;
  endtask

  // Wait (bounded) for the tick cycle, then move past the update edge.
  task automatic next_tick;
    int c;
    c = 0;
    while ((tick_s1 !== 1'b1) && (c < 8)) begin
      step_cycle;
      c++;
    end
    n_checks++;
    if (tick_s1 !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick_s1, c);
    end
    step_cycle;
  endtask

  // Scenarios ------------------------------------------------------------------
  task automatic test_reset;
    do_reset;
    n_checks++;
    if (duty_s1 !== {8'd1, 8'd1}) begin
      n_fail++; $display("FAIL reset_duty: got %h required 0101", duty_s1);
    end
    n_checks++;
    if (done_s1 !== 2'b00 || tick_s1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_done_tick: done=%b tick=%b required 00/0", done_s1, tick_s1);
    end
    set_mode(0, MODE_TRI);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) next_tick;
    n_checks++;
    if (duty_s1[7:0] !== 8'd6) begin
      n_fail++; $display("FAIL pre_reset_duty: got %0d required 6", duty_s1[7:0]);
    end
    // Assert reset between edges and look before the next clock edge.
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (duty_s1 !== {8'd1, 8'd1} || duty_s4 !== {8'd1, 8'd1}) begin
      n_fail++; $display("FAIL async_reset_duty: got %h/%h required 0101", duty_s1, duty_s4);
    end
    n_checks++;
    if (done_s1 !== 2'b00 || tick_s1 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_done_tick: done=%b tick=%b required 00/0", done_s1, tick_s1);
    end
    @(negedge clk);
    rst = 1'b0;
    step_cycle;
  endtask

  task automatic test_tri;
    do_reset;
    set_mode(0, MODE_TRI);
    enable = 1'b1;
    for (int n = 1; n <= 197; n++) begin
      next_tick;
      if (n == 1 || n == 98 || n == 99 || n == 196 || n == 197) begin
        int exp_d;
        exp_d = (n <= 98) ? 1 + n : (n <= 196 ? 197 - n : 2);
        n_checks++;
        if (duty_s1[7:0] !== 8'(exp_d)) begin
          n_fail++; $display("FAIL tri_sweep tick %0d: got %0d required %0d", n, duty_s1[7:0], exp_d);
        end
      end
    end
    n_checks++;
    if (duty_s1[15:8] !== 8'd1 || done_s1 !== 2'b00) begin
      n_fail++; $display("FAIL tri_ch1_idle: ch1=%0d done=%b required 1/00", duty_s1[15:8], done_s1);
    end
  endtask

  task automatic test_slew_short;
    int exp_d[4]   = '{5, 9, 10, 10};
    bit exp_dn[4]  = '{0, 0, 1, 0};
    do_reset;
    set_mode(0, MODE_SLEW);
    set_target(0, 8'd10);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_tick;
      n_checks++;
      if (duty_s4[7:0] !== 8'(exp_d[i]) || done_s4[0] !== exp_dn[i]) begin
        n_fail++;
        $display("FAIL slew_to_10 tick %0d: duty=%0d done=%b required %0d/%b",
                 i + 1, duty_s4[7:0], done_s4[0], exp_d[i], exp_dn[i]);
      end
    end
  endtask

  task automatic test_slew_park;
    do_reset;
    set_mode(1, MODE_SLEW);
    set_target(1, 8'd200);
    enable = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      int exp_d;
      next_tick;
      exp_d = (k < 25) ? 1 + 4 * k : 99;
      n_checks++;
      if (duty_s4[15:8] !== 8'(exp_d) || done_s4[1] !== (k == 25)) begin
        n_fail++;
        $display("FAIL slew_park_hi tick %0d: duty=%0d done=%b required %0d/%b",
                 k, duty_s4[15:8], done_s4[1], exp_d, (k == 25));
      end
    end
    set_target(1, 8'd0);
    for (int k = 1; k <= 26; k++) begin
      int exp_d;
      next_tick;
      exp_d = (k < 25) ? 99 - 4 * k : 1;
      n_checks++;
      if (duty_s4[15:8] !== 8'(exp_d) || done_s4[1] !== (k == 25)) begin
        n_fail++;
        $display("FAIL slew_park_lo tick %0d: duty=%0d done=%b required %0d/%b",
                 k, duty_s4[15:8], done_s4[1], exp_d, (k == 25));
      end
    end
    n_checks++;
    if (duty_s4[7:0] !== 8'd1 || done_s4[0] !== 1'b0) begin
      n_fail++; $display("FAIL park_ch0_hold: ch0=%0d done=%b required 1/0", duty_s4[7:0], done_s4[0]);
    end
  endtask

  task automatic test_freeze;
    do_reset;
    set_mode(0, MODE_TRI);
    enable = 1'b1;
    for (int i = 0; i < 39; i++) next_tick;
    n_checks++;
    if (duty_s1[7:0] !== 8'd40) begin
      n_fail++; $display("FAIL freeze_pre: got %0d required 40", duty_s1[7:0]);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_cycle;
      n_checks++;
      if (duty_s1[7:0] !== 8'd40 || tick_s1 !== 1'b0) begin
        n_fail++; $display("FAIL freeze_hold cycle %0d: duty=%0d tick=%b required 40/0", i, duty_s1[7:0], tick_s1);
      end
    end
    enable = 1'b1;
    n_checks++;
    if (tick_s1 !== 1'b0) begin
      n_fail++; $display("FAIL resume_cycle1_tick: got %b required 0", tick_s1);
    end
    step_cycle;
    n_checks++;
    if (tick_s1 !== 1'b1 || duty_s1[7:0] !== 8'd40) begin
      n_fail++; $display("FAIL resume_cycle2: tick=%b duty=%0d required 1/40", tick_s1, duty_s1[7:0]);
    end
    step_cycle;
    n_checks++;
    if (duty_s1[7:0] !== 8'd41) begin
      n_fail++; $display("FAIL resume_update: got %0d required 41", duty_s1[7:0]);
    end
  endtask

  task automatic test_mixed;
    do_reset;
    set_mode(0, MODE_TRI);
    set_mode(1, MODE_SLEW);
    set_target(1, 8'd50);
    enable = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      int e0, e1;
      next_tick;
      e0 = (k <= 32) ? 1 + 3 * k : (k == 33 ? 99 : 96);
      e1 = (k <= 16) ? 1 + 3 * k : 50;
      n_checks++;
      if (duty_s3[7:0] !== 8'(e0) || duty_s3[15:8] !== 8'(e1) ||
          done_s3 !== {(k == 17), 1'b0}) begin
        n_fail++;
        $display("FAIL mixed tick %0d: ch0=%0d ch1=%0d done=%b required %0d/%0d/%b",
                 k, duty_s3[7:0], duty_s3[15:8], done_s3, e0, e1, {(k == 17), 1'b0});
      end
    end
  endtask

  task automatic test_mode_switch;
    int exp_d[8]  = '{9, 8, 7, 6, 5, 5, 5, 6};
    bit exp_dn[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    do_reset;
    set_mode(0, MODE_TRI);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) next_tick;
    n_checks++;
    if (duty_s1[7:0] !== 8'd10) begin
      n_fail++; $display("FAIL switch_pre: got %0d required 10", duty_s1[7:0]);
    end
    set_mode(0, MODE_SLEW);
    set_target(0, 8'd5);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) set_mode(0, 2'b11);
      if (i == 7) set_mode(0, MODE_TRI);
      next_tick;
      n_checks++;
      if (duty_s1[7:0] !== 8'(exp_d[i]) || done_s1[0] !== exp_dn[i]) begin
        n_fail++;
        $display("FAIL mode_switch step %0d: duty=%0d done=%b required %0d/%b",
                 i, duty_s1[7:0], done_s1[0], exp_d[i], exp_dn[i]);
      end
    end
  endtask

  // Watchdog: the sequence is a few thousand cycles at most.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    ch_mode   = '0;
    ch_target = '0;
    test_reset;
    test_tri;
    test_slew_short;
    test_slew_park;
    test_freeze;
    test_mixed;
    test_mode_switch;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
